// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The op encodings match those used by the control unit.
package mdu_iter_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_RSVD  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } mdu_state_e;

   function automatic logic op_valid(input mdu_op_e op);
      return op != OP_RSVD;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               flush;
   logic               busy;
   logic               stall_req;
   logic               done;
   logic               we_hilo;
   logic [2*WIDTH-1:0] hilo_d;

   modport master (
      output start, op, a, b, flush,
      input  busy, stall_req, done, we_hilo, hilo_d
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, stall_req, done, we_hilo, hilo_d
   );
endinterface

// File: rtl/mdu_iter_dp.sv
// Shared shift register for shift-add multiply and restoring divide.
// Exposes the next-step values so the parent can latch the final result.
module mdu_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] lo_init_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] hi_nxt_o,
   output logic [WIDTH-1:0] lo_nxt_o
);
   logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
   logic [WIDTH:0]   sum, shrem;
   logic             ge;

   // Multiply: lo holds the multiplier and shifts right as the product fills in.
   // Divide: lo holds the dividend, shifts left and collects quotient bits.
   always_comb begin
      sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      shrem    = {hi_q, lo_q[WIDTH-1]};
      ge       = shrem >= {1'b0, opnd_q};
      hi_nxt_o = sum[WIDTH:1];
      lo_nxt_o = {sum[0], lo_q[WIDTH-1:1]};
      if (div_i) begin
         hi_nxt_o = ge ? WIDTH'(shrem - {1'b0, opnd_q}) : shrem[WIDTH-1:0];
         lo_nxt_o = {lo_q[WIDTH-2:0], ge};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
      end else if (load_i) begin
         hi_q   <= '0;
         lo_q   <= lo_init_i;
         opnd_q <= opnd_i;
      end else if (step_i) begin
         hi_q   <= hi_nxt_o;
         lo_q   <= lo_nxt_o;
      end
   end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULTU/MULT/DIVU unit: FSM, iteration counter, sign fix-up
// and pipeline stall/handshake generation around mdu_iter_dp.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = MDU_CNT_W
) (
   input  logic      clk,
   input  logic      rst,
   mdu_iter_if.slave bus
);
   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               div_q, neg_q;
   logic [2*WIDTH-1:0] hilo_q;
   mdu_op_e            op_e;
   logic               accept, last, finish;
   logic               busy, done;
   logic               op_div, op_mult;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic [2*WIDTH-1:0] raw;

   assign op_e    = mdu_op_e'(bus.op);
   assign op_div  = (op_e == OP_DIVU);
   assign op_mult = (op_e == OP_MULT);

   // Flush beats a same-cycle start; a running operation ignores start.
   assign accept = bus.start & ~bus.flush & op_valid(op_e) & (state_q != S_RUN);
   assign last   = (cnt_q == CNT_W'(WIDTH-1));
   assign finish = (state_q == S_RUN) & ~bus.flush & last;

   assign a_mag = (op_mult && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag = (op_mult && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   mdu_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .step_i    (state_q == S_RUN),
      .div_i     (div_q),
      .lo_init_i (op_div ? bus.a : b_mag),
      .opnd_i    (op_div ? bus.b : a_mag),
      .hi_nxt_o  (hi_nxt),
      .lo_nxt_o  (lo_nxt)
   );

   assign raw = {hi_nxt, lo_nxt};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (bus.flush) state_d = S_IDLE;
                  else if (last) state_d = S_DONE;
         S_DONE:  state_d = accept ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept)                 cnt_d = '0;
      else if (state_q == S_RUN)  cnt_d = cnt_q + CNT_W'(1);
   end

   // The final step's result is taken straight from the datapath's next values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         hilo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            div_q <= op_div;
            neg_q <= op_mult & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         end
         if (finish) hilo_q <= neg_q ? -raw : raw;
      end
   end

   assign bus.busy      = busy;
   assign bus.stall_req = busy | accept;
   assign bus.done      = done;
   assign bus.we_hilo   = done;
   assign bus.hilo_d    = hilo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against a plain-arithmetic model.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  mdu_iter_if #(.WIDTH(W)) bus();

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0:    model = {32'b0, a} * {32'b0, b};
      2'd1:    model = sa * sb;
      2'd2:    model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: model = 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       pick = 32'($urandom_range(0, 15));
      1:       pick = edges[$urandom_range(0, 4)];
      default: pick = $urandom;
    endcase
  endfunction

  // Issue at cycle 0, expect done/we_hilo at cycle 33 with the model result.
  // A nonzero glitch re-asserts start with junk operands at that RUN cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int glitch);
    logic [63:0] exp;
    int n;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1 chk("stall_on_start", 64'(bus.stall_req), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == glitch) begin
        bus.start = 1'b1; bus.op = 2'($urandom_range(0, 2)); bus.a = $urandom; bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 60);
    chk("latency", 64'(n), 64'd33);
    chk("we_hilo", 64'(bus.we_hilo), 64'd1);
    chk("hilo", bus.hilo_d, exp);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] old, e1, e2;
    logic [31:0] a1, b1, a2, b2;
    int pulses, n;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_we", 64'(bus.we_hilo), 64'd0);
    chk("rst_hilo", bus.hilo_d, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_stall", 64'(bus.stall_req), 64'd0);

    do_op(2'd0, 32'd2, 32'd4, 0);
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd1, -32'sd3, 32'd5, 0);
    do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(2'd2, 32'd100, 32'd7, 0);
    do_op(2'd2, 32'd9, 32'd0, 0);

    for (int i = 0; i < 30; i++)
      do_op(2'($urandom_range(0, 2)), pick(), pick(), (i % 5 == 0) ? 5 : 0);

    // Flush mid-RUN: back to IDLE next cycle, no write, result held.
    old = bus.hilo_d;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'h1234; bus.b = 32'h5678;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("flush_busy_c10", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_idle_c11", 64'(bus.busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.we_hilo) pulses++;
    end
    chk("flush_no_we", 64'(pulses), 64'd0);
    chk("flush_hold", bus.hilo_d, old);

    // Reserved op is never accepted.
    bus.start = 1'b1; bus.op = 2'd3;
    #1 chk("rsvd_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rsvd_busy", 64'(bus.busy), 64'd0);

    // Start and flush together in IDLE: flush wins.
    bus.start = 1'b1; bus.op = 2'd0; bus.flush = 1'b1;
    #1 chk("sf_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("sf_busy", 64'(bus.busy), 64'd0);

    // Back-to-back: second start in the DONE cycle.
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom | 32'h8000_0000; b2 = 32'($urandom_range(1, 1000));
    e1 = model(2'd0, a1, b1);
    e2 = model(2'd2, a2, b2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = a1; bus.b = b1;
    n = 0;
    do begin @(negedge clk); n++; bus.start = 1'b0; end while (!bus.done && n < 60);
    chk("b2b_lat1", 64'(n), 64'd33);
    chk("b2b_hilo1", bus.hilo_d, e1);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = a2; bus.b = b2;
    #1 chk("b2b_stall", 64'(bus.stall_req), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; bus.start = 1'b0; end while (!bus.done && n < 60);
    chk("b2b_lat2", 64'(n), 64'd33);
    chk("b2b_we2", 64'(bus.we_hilo), 64'd1);
    chk("b2b_hilo2", bus.hilo_d, e2);

    // Asynchronous reset mid-RUN clears everything at once.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = $urandom; bus.b = $urandom;
    repeat (10) begin @(negedge clk); bus.start = 1'b0; end
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_we", 64'(bus.we_hilo), 64'd0);
    chk("arst_stall", 64'(bus.stall_req), 64'd0);
    chk("arst_hilo", bus.hilo_d, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    do_op(2'd1, 32'hFFFF_FFF9, 32'd6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
